tile_pixel_pipe: RTL
====================

# tile_pixel_pipe

Parametrised, pipelined tilemap pixel renderer: takes a stream of screen (col,row) coordinates, looks up the tile index and attributes from a tilemap memory, fetches the 2bpp pattern byte, decodes the pixel, and resolves it through a palette memory to 12-bit RGB. It sits between the VGA timing generator and the sprite mixer.

## Interface
Parameters:
- MAP_W, 28: tilemap width in tiles.
- MAP_H, 36: tilemap height in tiles.
- TILE_IDX_W, 8: tile index width, giving 2^TILE_IDX_W patterns of 16 bytes.
- PAL_W, 4: palette-select width per map entry.
- BORDER_RGB, 12'h000: colour emitted for coordinates outside the map.

Ports:
- clk  in  1  clock; one clock domain.
- rst_L  in  1  asynchronous, active-low reset.
- in_valid  in  1  coordinate valid.
- in_ready  out  1  pipe accepts a coordinate this cycle.
- in_col  in  10  screen column.
- in_row  in  9  screen row.
- mem_en  out  1  read enable shared by all three memories; a memory holds its output while low.
- map_addr  out  $clog2(MAP_W*MAP_H)  tilemap address.
- map_data  in  TILE_IDX_W+PAL_W+2  {flip_y, flip_x, pal, tile_idx}; valid one cycle after address with mem_en high.
- pat_addr  out  TILE_IDX_W+4  {tile_idx, byte_idx}.
- pat_data  in  8  pattern byte, one-cycle latency.
- pal_addr  out  PAL_W+2  {pal, pix}.
- pal_data  in  12  {r,g,b}, one-cycle latency.
- out_valid  out  1  pixel valid.
- out_ready  in  1  downstream accepts the pixel.
- out_rgb  out  12  {red[3:0], green[3:0], blue[3:0]}.
- out_transparent  out  1  decoded pixel value was 0, or the pixel is a border pixel.

## Operation
- Four stages, S0 to S3, with one valid bit each (v1, v2, v3 = out_valid).
- advance = ~out_valid | out_ready. in_ready = advance. mem_en = advance. The whole pipe stalls as one unit; there are no bubbles-collapse.
- S0, on accept: tx = col[9:3], ty = row[8:3], cx = col[2:0], cy = row[2:0].
  - oob = (tx >= MAP_W) | (ty >= MAP_H).
  - map_addr = ty*MAP_W + tx. When oob, map_addr = 0.
  - cx, cy and oob are registered into S1.
- S1: apply flips. ex = flip_x ? ~cx : cx. ey = flip_y ? ~cy : cy.
  - byte_idx = {ex[2], ey[2:0]}. pat_addr = {tile_idx, byte_idx}.
  - k = ex[1:0], pal and oob are registered into S2.
- S2: pix = {pat_data[4+k], pat_data[k]}. pal_addr = {pal, pix}. pix == 0 and oob are registered into S3.
- S3: out_rgb = oob ? BORDER_RGB : pal_data. out_transparent = oob | (pix == 0).
- Decode logic lives in a sub-module; the plane convention matches the existing hardcoded tile demo.
- out_rgb and out_transparent are held stable while out_valid & ~out_ready.

## Timing
- Reset (asynchronous, rst_L low): v1, v2, v3 = 0; out_rgb = 0; out_transparent = 0; all addresses 0. in_ready = 1 immediately after reset.
- Latency: a coordinate accepted at edge N appears on out_valid after edge N+3 when there is no stall. Throughput is 1 pixel per clock.
- Stall: while out_valid & ~out_ready, no register, valid bit or memory output changes.
- Simultaneous out_ready and in_valid with a full pipe: the pipe shifts and accepts in the same cycle.
- in_valid = 0 while advancing inserts a bubble (v1 = 0); bubbles propagate and are never dropped or collapsed.
- Reset asserted mid-stream flushes all in-flight pixels; there is no partial output.
- Map address arithmetic is unsigned. ty*MAP_W uses a constant multiply, widened to the map_addr width.

## Structure
- Package tile_pkg: map-entry struct {flip_y, flip_x, pal, tile_idx}, RGB12 typedef, and the TILE_BYTES = 16 constant.
- Sub-module tile_pixel_decode (combinational): (ex, ey, byte) -> byte_idx, pix. It replaces the separate pixel_num and pixel_data_dcd pair.
- Memories are external to this block; the bench supplies behavioural synchronous-read models.

## Test plan
- Reset, then stream (0,0)..(7,0) with map[0] = 0x00 and tile 0 loaded with the 16 bytes cc,ee,11,11,33,ee,cc,00,11,33,66,44,44,33,11,00.
  - Required: first out_valid exactly 3 cycles after the first accept.
  - Required: pixel values match the reference decode; pix 0 gives out_transparent = 1.
- flip_x = 1 on the map entry: pixels for cx = 0..7 equal the unflipped pixels for cx = 7..0. Same check for flip_y with rows.
- Coordinates (224,0) and (0,288), which are out of the map for MAP_W = 28 and MAP_H = 36 -> out_rgb = BORDER_RGB, out_transparent = 1.
- Full pipe with out_ready held low for 5 cycles -> in_ready = 0, out_rgb stable.
  - On release, all pixels emerge in order with no loss or duplication.
- Random in_valid gaps combined with random out_ready -> the output sequence equals the input sequence mapped through the reference model.
- rst_L pulsed low mid-stream for a fraction of a cycle -> out_valid = 0 immediately.
  - After release, no stale pixels are emitted.

Source files
------------

// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared types and helpers for the tilemap pixel pipe
package tile_pkg;

    localparam int TILE_BYTES     = 16;
    localparam int DEF_TILE_IDX_W = 8;
    localparam int DEF_PAL_W      = 4;

    typedef logic [11:0] rgb12_t;

    typedef struct packed {
        logic                      flip_y;
        logic                      flip_x;
        logic [DEF_PAL_W-1:0]      pal;
        logic [DEF_TILE_IDX_W-1:0] tile_idx;
    } map_entry_t;

    function automatic logic [2:0] apply_flip(input logic [2:0] c, input logic flip);
        return flip ? ~c : c;
    endfunction

endpackage

// File: rtl/tile_pixel_decode.sv
// rtl/tile_pixel_decode.sv - pattern byte addressing and 2bpp pixel extraction
module tile_pixel_decode (
    input  logic [2:0] ex,
    input  logic [2:0] ey,
    input  logic [1:0] k,
    input  logic [7:0] pat_byte,
    output logic [3:0] byte_idx,
    output logic [1:0] k_next,
    output logic [1:0] pix
);

    // Each byte holds four pixels: high plane in bits 7:4, low plane in bits 3:0.
    always_comb begin
        byte_idx = {ex[2], ey};
        k_next   = ex[1:0];
        pix      = {pat_byte[{1'b1, k}], pat_byte[{1'b0, k}]};
    end

endmodule

// File: rtl/tile_pixel_pipe.sv
// rtl/tile_pixel_pipe.sv - pipelined tilemap renderer: coordinate to 12-bit RGB
module tile_pixel_pipe
    import tile_pkg::*;
#(
    parameter int     MAP_W      = 28,
    parameter int     MAP_H      = 36,
    parameter int     TILE_IDX_W = 8,
    parameter int     PAL_W      = 4,
    parameter rgb12_t BORDER_RGB = 12'h000
) (
    input  logic                            clk,
    input  logic                            rst_L,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [9:0]                      in_col,
    input  logic [8:0]                      in_row,
    output logic                            mem_en,
    output logic [$clog2(MAP_W*MAP_H)-1:0]  map_addr,
    input  logic [TILE_IDX_W+PAL_W+1:0]     map_data,
    output logic [TILE_IDX_W+3:0]           pat_addr,
    input  logic [7:0]                      pat_data,
    output logic [PAL_W+1:0]                pal_addr,
    input  logic [11:0]                     pal_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [11:0]                     out_rgb,
    output logic                            out_transparent
);

    localparam int MAP_AW = $clog2(MAP_W*MAP_H);
    localparam int MAP_DW = TILE_IDX_W + PAL_W + 2;

    logic                  advance;
    logic [6:0]            tx0;
    logic [5:0]            ty0;
    logic                  oob0;
    logic [TILE_IDX_W-1:0] map_tile;
    logic [PAL_W-1:0]      map_pal;
    logic                  map_flip_x, map_flip_y;
    logic [2:0]            ex1, ey1;
    logic [3:0]            byte_idx1;
    logic [1:0]            k1;
    logic [1:0]            pix2;

    logic                  v1_q, v1_d, oob1_q, oob1_d;
    logic [2:0]            cx1_q, cx1_d, cy1_q, cy1_d;
    logic                  v2_q, v2_d, oob2_q, oob2_d;
    logic [1:0]            k2_q, k2_d;
    logic [PAL_W-1:0]      pal2_q, pal2_d;
    logic                  v3_q, v3_d, oob3_q, oob3_d, zero3_q, zero3_d;
    logic                  out_valid_q, out_valid_d;
    rgb12_t                out_rgb_q, out_rgb_d;
    logic                  out_transparent_q, out_transparent_d;

    // The memories share mem_en, so they freeze together with the stage registers.
    assign advance  = ~out_valid_q | out_ready;
    assign in_ready = advance;
    assign mem_en   = advance;

    always_comb begin
        tx0      = in_col[9:3];
        ty0      = in_row[8:3];
        oob0     = (32'(tx0) >= MAP_W) || (32'(ty0) >= MAP_H);
        map_addr = oob0 ? '0 : MAP_AW'(ty0) * MAP_AW'(MAP_W) + MAP_AW'(tx0);
    end

    always_comb begin
        map_tile   = map_data[TILE_IDX_W-1:0];
        map_pal    = map_data[TILE_IDX_W +: PAL_W];
        map_flip_x = map_data[MAP_DW-2];
        map_flip_y = map_data[MAP_DW-1];
        ex1        = apply_flip(cx1_q, map_flip_x);
        ey1        = apply_flip(cy1_q, map_flip_y);
    end

    tile_pixel_decode u_decode (
        .ex       (ex1),
        .ey       (ey1),
        .k        (k2_q),
        .pat_byte (pat_data),
        .byte_idx (byte_idx1),
        .k_next   (k1),
        .pix      (pix2)
    );

    assign pat_addr = {map_tile, byte_idx1};
    assign pal_addr = {pal2_q, pix2};

    always_comb begin
        v1_d              = v1_q;
        cx1_d             = cx1_q;
        cy1_d             = cy1_q;
        oob1_d            = oob1_q;
        v2_d              = v2_q;
        k2_d              = k2_q;
        pal2_d            = pal2_q;
        oob2_d            = oob2_q;
        v3_d              = v3_q;
        zero3_d           = zero3_q;
        oob3_d            = oob3_q;
        out_valid_d       = out_valid_q;
        out_rgb_d         = out_rgb_q;
        out_transparent_d = out_transparent_q;
        if (advance) begin
            v1_d              = in_valid;
            cx1_d             = in_col[2:0];
            cy1_d             = in_row[2:0];
            oob1_d            = oob0;
            v2_d              = v1_q;
            k2_d              = k1;
            pal2_d            = map_pal;
            oob2_d            = oob1_q;
            v3_d              = v2_q;
            zero3_d           = (pix2 == 2'd0);
            oob3_d            = oob2_q;
            out_valid_d       = v3_q;
            out_rgb_d         = oob3_q ? BORDER_RGB : pal_data;
            out_transparent_d = oob3_q | zero3_q;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            v1_q              <= 1'b0;
            cx1_q             <= '0;
            cy1_q             <= '0;
            oob1_q            <= 1'b0;
            v2_q              <= 1'b0;
            k2_q              <= '0;
            pal2_q            <= '0;
            oob2_q            <= 1'b0;
            v3_q              <= 1'b0;
            zero3_q           <= 1'b0;
            oob3_q            <= 1'b0;
            out_valid_q       <= 1'b0;
            out_rgb_q         <= '0;
            out_transparent_q <= 1'b0;
        end else begin
            v1_q              <= v1_d;
            cx1_q             <= cx1_d;
            cy1_q             <= cy1_d;
            oob1_q            <= oob1_d;
            v2_q              <= v2_d;
            k2_q              <= k2_d;
            pal2_q            <= pal2_d;
            oob2_q            <= oob2_d;
            v3_q              <= v3_d;
            zero3_q           <= zero3_d;
            oob3_q            <= oob3_d;
            out_valid_q       <= out_valid_d;
            out_rgb_q         <= out_rgb_d;
            out_transparent_q <= out_transparent_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_rgb         = out_rgb_q;
    assign out_transparent = out_transparent_q;

endmodule
